// File: rtl/tt_pkg.sv
// Shared types and constants for the exhaustive 3-input truth-table checkers.
// Contents: FSM state enum, vector count, default expected truth tables.
package tt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        DONE
    } tt_state_t;

    localparam int unsigned TT_NUM_VECTORS = 8;

    // Truth table of ~x | y, bit i indexed by {x,y,z} = i.
    localparam logic [7:0] TT_EXP_NOTX_OR_Y = 8'hCF;

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable 4-bit down-counter used to time the DUT settle interval.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   load        - load count with load_value (takes priority over dec)
//   load_value  - value to load
//   dec         - decrement by one; holds at zero
//   expired     - high while the count equals 1 (last settle cycle)
module tt_settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       dec,
    output logic       expired
);

    logic [3:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 4'd1;
        end
    end

    assign expired = (count == 4'd1);

endmodule

// File: rtl/truth_table_checker.sv
// Response checker for the exhaustive 3-input truth-table test.
// Walks {x,y,z} through 000..111, waits SETTLE_CYCLES per vector, samples
// s1/s2 and compares them with EXP_S1/EXP_S2 (bit i = expected for vector i).
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   start          - begin a run (accepted only in IDLE or DONE)
//   x, y, z        - registered DUT inputs, x is MSB of vector index
//   s1, s2         - DUT outputs, same clock domain
//   busy           - run in progress
//   done           - run complete (level until next start or rst)
//   pass           - valid with done; 1 iff no vector failed
//   err_count      - number of failing vectors
//   mismatch_mask  - bit i set if vector i failed
//   vec_idx        - current vector index
module truth_table_checker
    import tt_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXP_S1        = TT_EXP_NOTX_OR_Y,
    parameter logic [7:0]  EXP_S2        = TT_EXP_NOTX_OR_Y
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       x,
    output logic       y,
    output logic       z,
    input  logic       s1,
    input  logic       s2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] mismatch_mask,
    output logic [2:0] vec_idx
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [2:0] LAST_VEC    = 3'(TT_NUM_VECTORS - 1);

    tt_state_t state, state_next;

    logic       accept;
    logic       apply;
    logic       sample;
    logic       timer_load;
    logic       timer_dec;
    logic       timer_expired;
    logic       vec_fail;
    logic       last_vec;
    logic [3:0] err_next;

    tt_settle_timer u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (SETTLE_LOAD),
        .dec        (timer_dec),
        .expired    (timer_expired)
    );

    // A vector failing both outputs contributes a single error.
    assign vec_fail = (s1 != EXP_S1[vec_idx]) || (s2 != EXP_S2[vec_idx]);
    assign err_next = err_count + {3'b000, vec_fail};
    assign last_vec = (vec_idx == LAST_VEC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        apply      = 1'b0;
        sample     = 1'b0;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = APPLY;
                end
            end
            APPLY: begin
                apply      = 1'b1;
                timer_load = 1'b1;
                state_next = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
            end
            SETTLE: begin
                // Leaving on count==1 gives exactly SETTLE_CYCLES cycles here.
                timer_dec = 1'b1;
                if (timer_expired) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                sample     = 1'b1;
                state_next = last_vec ? DONE : APPLY;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x             <= 1'b0;
            y             <= 1'b0;
            z             <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            mismatch_mask <= '0;
            vec_idx       <= '0;
        end else begin
            if (accept) begin
                busy          <= 1'b1;
                done          <= 1'b0;
                pass          <= 1'b0;
                err_count     <= '0;
                mismatch_mask <= '0;
                vec_idx       <= '0;
            end
            if (apply) begin
                {x, y, z} <= vec_idx;
            end
            if (sample) begin
                if (vec_fail) begin
                    mismatch_mask[vec_idx] <= 1'b1;
                end
                err_count <= err_next;
                if (last_vec) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (err_next == '0);
                end else begin
                    vec_idx <= vec_idx + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench for truth_table_checker: three instances with settle
// intervals 2, 0 and 5 share start/rst; a behavioural DUT (~x|y) with
// selectable faults drives each instance's s1/s2.
module tb_truth_table_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int unsigned mode = 0;       // 0: good, 1: s2 stuck at 1, 2: both inverted
    int unsigned edge_no = 0;
    int unsigned start_edge = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;

    logic [2:0] x_c, y_c, z_c, s1_c, s2_c, busy_c, done_c, pass_c;
    logic [3:0] err_c  [3];
    logic [7:0] mask_c [3];
    logic [2:0] vidx_c [3];

    typedef struct {
        logic [3:0]  err;
        logic [7:0]  mask;
        logic        pass;
        int unsigned end_edge;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_no <= edge_no + 1;

    always_comb begin
        s1_c = '0;
        s2_c = '0;
        for (int i = 0; i < 3; i++) begin
            logic f;
            f = ~x_c[i] | y_c[i];
            s1_c[i] = (mode == 2) ? ~f : f;
            s2_c[i] = (mode == 1) ? 1'b1 : ((mode == 2) ? ~f : f);
        end
    end

    truth_table_checker #(.SETTLE_CYCLES(2), .EXP_S1(8'hCF), .EXP_S2(8'hCF)) u_s2 (
        .clk(clk), .rst(rst), .start(start), .x(x_c[0]), .y(y_c[0]), .z(z_c[0]),
        .s1(s1_c[0]), .s2(s2_c[0]), .busy(busy_c[0]), .done(done_c[0]), .pass(pass_c[0]),
        .err_count(err_c[0]), .mismatch_mask(mask_c[0]), .vec_idx(vidx_c[0]));

    truth_table_checker #(.SETTLE_CYCLES(0), .EXP_S1(8'hCF), .EXP_S2(8'hCF)) u_s0 (
        .clk(clk), .rst(rst), .start(start), .x(x_c[1]), .y(y_c[1]), .z(z_c[1]),
        .s1(s1_c[1]), .s2(s2_c[1]), .busy(busy_c[1]), .done(done_c[1]), .pass(pass_c[1]),
        .err_count(err_c[1]), .mismatch_mask(mask_c[1]), .vec_idx(vidx_c[1]));

    truth_table_checker #(.SETTLE_CYCLES(5), .EXP_S1(8'hCF), .EXP_S2(8'hCF)) u_s5 (
        .clk(clk), .rst(rst), .start(start), .x(x_c[2]), .y(y_c[2]), .z(z_c[2]),
        .s1(s1_c[2]), .s2(s2_c[2]), .busy(busy_c[2]), .done(done_c[2]), .pass(pass_c[2]),
        .err_count(err_c[2]), .mismatch_mask(mask_c[2]), .vec_idx(vidx_c[2]));

    function automatic int unsigned settle_of(input int unsigned i);
        case (i)
            0: return 2;
            1: return 0;
            default: return 5;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_expected(input logic [3:0] err, input logic [7:0] mask, input logic p);
        for (int unsigned i = 0; i < 3; i++) begin
            exp_t e;
            e.err      = err;
            e.mask     = mask;
            e.pass     = p;
            e.end_edge = start_edge + 8 * (settle_of(i) + 2);
            case (i)
                0: q0.push_back(e);
                1: q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    // Caller must be positioned at a negedge; returns at the next negedge.
    task automatic issue_start(input bit accepted, input logic [3:0] err,
                               input logic [7:0] mask, input logic p);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (accepted) begin
            start_edge = edge_no;
            push_expected(err, mask, p);
        end
        @(negedge clk);
        start = 1'b0;
        if (accepted) begin
            check("busy_after_start", {29'd0, busy_c}, 32'h7);
            check("done_after_start", {29'd0, done_c}, 32'h0);
        end
    endtask

    task automatic wait_all_done(input int unsigned limit);
        int unsigned n = 0;
        while (!(&done_c) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("all_done_within_budget", {31'd0, &done_c}, 32'h1);
        @(negedge clk);
        check("scoreboard_drained", q0.size() + q1.size() + q2.size(), 32'h0);
    endtask

    task automatic check_all_zero(input string name);
        for (int unsigned i = 0; i < 3; i++) begin
            check($sformatf("%s_inst%0d", name, i),
                  {busy_c[i], done_c[i], pass_c[i], err_c[i], mask_c[i], vidx_c[i],
                   x_c[i], y_c[i], z_c[i]}, 32'h0);
        end
    endtask

    // Scoreboard monitor: pops one expectation per done rising edge.
    initial begin
        logic [2:0] prev_done = '0;
        forever begin
            @(negedge clk);
            for (int unsigned i = 0; i < 3; i++) begin
                if (rst) begin
                    prev_done[i] = 1'b0;
                end else begin
                    if (done_c[i] && !prev_done[i]) begin
                        int unsigned sz;
                        sz = (i == 0) ? q0.size() : ((i == 1) ? q1.size() : q2.size());
                        check($sformatf("inst%0d_done_expected", i), {31'd0, sz != 0}, 32'h1);
                        if (sz != 0) begin
                            exp_t e;
                            case (i)
                                0: e = q0.pop_front();
                                1: e = q1.pop_front();
                                default: e = q2.pop_front();
                            endcase
                            check($sformatf("inst%0d_err_count", i), {28'd0, err_c[i]}, {28'd0, e.err});
                            check($sformatf("inst%0d_mismatch_mask", i), {24'd0, mask_c[i]}, {24'd0, e.mask});
                            check($sformatf("inst%0d_pass", i), {31'd0, pass_c[i]}, {31'd0, e.pass});
                            check($sformatf("inst%0d_done_edge", i), edge_no, e.end_edge);
                            check($sformatf("inst%0d_busy_at_done", i), {31'd0, busy_c[i]}, 32'h0);
                            check($sformatf("inst%0d_xyz_at_done", i),
                                  {29'd0, x_c[i], y_c[i], z_c[i]}, 32'h7);
                        end
                    end
                    prev_done[i] = done_c[i];
                end
            end
        end
    end

    // Vector-order monitor on the SETTLE_CYCLES=2 instance.
    initial begin
        logic [2:0]  prev_xyz  = '0;
        logic        prev_busy = 1'b0;
        int unsigned exp_vec   = 0;
        logic [2:0]  cur;
        forever begin
            @(negedge clk);
            cur = {x_c[0], y_c[0], z_c[0]};
            if (rst) begin
                prev_busy = 1'b0;
            end else begin
                if (busy_c[0] && !prev_busy) begin
                    exp_vec = (cur == 3'b000) ? 1 : 0;
                end
                if (busy_c[0] && cur != prev_xyz) begin
                    check("xyz_order", {29'd0, cur}, exp_vec);
                    check("xyz_change_edge", edge_no, start_edge + 1 + exp_vec * 4);
                    exp_vec++;
                end
                if (!busy_c[0] && prev_busy) begin
                    check("xyz_vectors_seen", exp_vec, 32'd8);
                end
                prev_busy = busy_c[0];
            end
            prev_xyz = cur;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);

        // Good DUT, plus an ignored start pulse at edge 5 of the run.
        mode = 0;
        issue_start(1'b1, 4'd0, 8'h00, 1'b1);
        while (edge_no < start_edge + 4) @(negedge clk);
        issue_start(1'b0, 4'd0, 8'h00, 1'b0);
        wait_all_done(200);

        // Restart from DONE: same results.
        issue_start(1'b1, 4'd0, 8'h00, 1'b1);
        wait_all_done(200);

        // s2 stuck at 1: vectors 4 and 5 fail.
        mode = 1;
        issue_start(1'b1, 4'd2, 8'h30, 1'b0);
        wait_all_done(200);

        // Both outputs inverted: every vector fails once.
        mode = 2;
        issue_start(1'b1, 4'd8, 8'hFF, 1'b0);
        wait_all_done(200);

        // Reset at edge 10 of a run discards it.
        mode = 0;
        issue_start(1'b1, 4'd0, 8'h00, 1'b1);
        do begin
            @(posedge clk);
            #1;
        end while (edge_no < start_edge + 10);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        q2.delete();
        @(negedge clk);
        check_all_zero("mid_run_reset");
        rst = 1'b0;
        repeat (70) @(negedge clk);
        check("idle_after_reset_busy", {29'd0, busy_c}, 32'h0);
        check("idle_after_reset_done", {29'd0, done_c}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Synthesizable response side of the exhaustive 3-input truth-table test used on the boolean-function blocks.
- On start, walks all 8 input vectors {x,y,z} = 000..111 into a combinational DUT and waits a settle interval for each.
- Samples the DUT's two outputs s1/s2 and compares them against programmed expected truth tables.
- Reports per-vector mismatches, an error count and a pass flag; replaces manual inspection of printed tables.

Parameters:
- SETTLE_CYCLES, 2, wait cycles between driving a vector and sampling; 0 to 15 legal.
- EXP_S1, 8'hCF, expected s1 truth table; bit i = expected s1 for {x,y,z} = i. Default is s1 = ~x | y.
- EXP_S2, 8'hCF, expected s2 truth table, same indexing.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a run; sampled only in IDLE or DONE
- x  output  1  DUT input, registered, MSB of vector index
- y  output  1  DUT input, registered
- z  output  1  DUT input, registered, LSB of vector index
- s1  input  1  DUT output 1
- s2  input  1  DUT output 2
- busy  output  1  high from start acceptance until done rises
- done  output  1  level; high after the run completes, until the next start or rst
- pass  output  1  valid while done; 1 iff err_count == 0
- err_count  output  4  number of failing vectors, 0..8
- mismatch_mask  output  8  bit i set if vector i failed on s1 or s2
- vec_idx  output  3  current vector index

Behaviour:
- Reset: all outputs 0 and state IDLE. Applies immediately and asynchronously, including mid-run; the partial run is discarded.
- States: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE or DONE with start=1: clear err_count, mismatch_mask, done and pass; set vec_idx=0 and busy=1; go to APPLY.
- IDLE or DONE with start=0: hold all outputs.
- APPLY (1 cycle): register {x,y,z} <= vec_idx and load the settle counter with SETTLE_CYCLES. Go to SETTLE, or straight to SAMPLE if SETTLE_CYCLES=0.
- SETTLE: decrement the counter each cycle. Go to SAMPLE on the cycle the counter reaches 1, giving exactly SETTLE_CYCLES cycles in SETTLE.
- SAMPLE (1 cycle): a vector fails if s1 != EXP_S1[vec_idx] or s2 != EXP_S2[vec_idx].
  - On failure: set mismatch_mask[vec_idx] and increment err_count. A vector failing both outputs counts once.
  - If vec_idx==7: go to DONE, busy=0, done=1, pass=(final err_count==0).
  - Otherwise: vec_idx increments and state returns to APPLY.
- Timing: each vector takes SETTLE_CYCLES+2 cycles. done rises on edge 8*(SETTLE_CYCLES+2) after the edge that accepted start; 32 edges with defaults.
- err_count saturates naturally at 8; no wrap is possible in 4 bits.
- start while busy is ignored; no restart or abort.
- start in DONE restarts the run; done drops on the accepting edge.
- x/y/z hold the last driven vector (111) in DONE; they return to 000 only on rst.
- s1/s2 are treated as settled at SAMPLE. No synchronizers; the DUT is on clk's domain.

Decomposition:
- Shared package tt_pkg holds:
  - state enum tt_state_t (IDLE, APPLY, SETTLE, SAMPLE, DONE)
  - constant TT_NUM_VECTORS = 8
  - default expected-table constants (TT_EXP_NOTX_OR_Y = 8'hCF)
- One sub-module, tt_settle_timer: loadable 4-bit down-counter with a load input and an expiry flag, reusable by later checkers.

Test Plan:
- DUT computes ~x|y for both outputs; defaults; pulse start -> done at edge 32, pass=1, err_count=0, mismatch_mask=8'h00.
- s2 forced to the constant 1 -> vectors 4 and 5 fail -> err_count=2, mismatch_mask=8'h30, pass=0.
- s1 and s2 both inverted -> every vector fails once -> err_count=8, mismatch_mask=8'hFF, pass=0.
- SETTLE_CYCLES=0 -> done at edge 16; SETTLE_CYCLES=5 -> done at edge 56.
- Check that x/y/z step through 000..111 in order.
- Assert rst at edge 10 of a run -> all outputs 0, state IDLE.
  - Second start pulse at edge 5 of a run -> ignored, done timing unchanged.
  - start in DONE -> clean second run with the same results.
